// File: rtl/ifq_pkg.sv
// Shared types and sizing helpers for the instruction fetch queue.
package ifq_pkg;

  localparam int IFQ_XLEN = 32;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_XLEN-1:0] inst;
    logic                filled;
    logic                misalign;
  } ifq_entry_t;

  function automatic int ifq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the decode stage.
interface instr_fetch_queue_if #(
  parameter int XLEN = ifq_pkg::IFQ_XLEN
);
  logic            io_imem_req_valid;
  logic            io_imem_req_ready;
  logic [XLEN-1:0] io_imem_req_addr;
  logic            io_imem_resp_valid;
  logic [XLEN-1:0] io_imem_resp_data;
  logic            io_dec_valid;
  logic            io_dec_ready;
  logic [XLEN-1:0] io_dec_pc;
  logic [XLEN-1:0] io_dec_inst;
  logic            io_dec_misalign;

  modport master (
    output io_imem_req_valid, io_imem_req_addr,
    input  io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
    output io_dec_valid, io_dec_pc, io_dec_inst, io_dec_misalign,
    input  io_dec_ready
  );

  modport slave (
    input  io_imem_req_valid, io_imem_req_addr,
    output io_imem_req_ready, io_imem_resp_valid, io_imem_resp_data,
    input  io_dec_valid, io_dec_pc, io_dec_inst, io_dec_misalign,
    output io_dec_ready
  );
endinterface

// File: rtl/ifq_ring.sv
// DEPTH-entry ring of {pc, inst, filled, misalign} with head (pop), tail (alloc) and fill pointers.
// The fill target is the oldest allocated entry still waiting for its instruction word.
module ifq_ring
  import ifq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = ifq_ptr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                alloc_en,
  input  logic [IFQ_XLEN-1:0] alloc_pc,
  input  logic                alloc_misalign,
  input  logic                fill_en,
  input  logic [IFQ_XLEN-1:0] fill_inst,
  input  logic                pop_en,
  output ifq_entry_t          head_entry,
  output logic [CW-1:0]       cnt,
  output logic [CW-1:0]       outstanding,
  output logic                has_unfilled
);

  ifq_entry_t    entries_q [DEPTH];
  ifq_entry_t    entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [PW-1:0] fill_ptr, idx, off;
  logic [CW-1:0] cnt_q, cnt_d;

  // Scan forward from fill_q so pre-filled (misaligned) entries are skipped.
  always_comb begin
    fill_ptr     = tail_q;
    has_unfilled = 1'b0;
    outstanding  = '0;
    idx          = '0;
    off          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = fill_q + PW'(i);
      off = idx - head_q;
      if (!has_unfilled && ({1'b0, off} < cnt_q) && !entries_q[idx].filled) begin
        fill_ptr     = idx;
        has_unfilled = 1'b1;
      end
      idx = PW'(i);
      off = idx - head_q;
      if (({1'b0, off} < cnt_q) && !entries_q[idx].filled) begin
        outstanding = outstanding + CW'(1);
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_ptr;
    cnt_d     = cnt_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[PW'(i)].filled = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else begin
      if (fill_en) begin
        entries_d[fill_ptr].inst   = fill_inst;
        entries_d[fill_ptr].filled = 1'b1;
        fill_d                     = fill_ptr + 1'b1;
      end
      if (pop_en) begin
        entries_d[head_q].filled = 1'b0;
        head_d                   = head_q + 1'b1;
      end
      if (alloc_en) begin
        entries_d[tail_q] = '{pc: alloc_pc, inst: '0, filled: alloc_misalign, misalign: alloc_misalign};
        tail_d            = tail_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(alloc_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
    end
  end

  assign head_entry = entries_q[head_q];
  assign cnt        = cnt_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: requests io_pc from imem in order and buffers {pc, inst} for decode.
// Optional feature macro IFQ_MISALIGN_CHECK_EN: misaligned PCs become pre-filled entries with no imem request.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int XLEN  = IFQ_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_pc,
  input  logic            io_flush,
  output logic            io_stall_en,
  instr_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] cnt, outstanding, drop_cnt_q, drop_cnt_d;
  logic          has_unfilled, space, pc_misaligned, req_fire, alloc_en, fill_en, pop_en;
  ifq_entry_t    head_entry;

  always_comb begin
    space = ~reset & ~io_flush & (cnt < CW'(DEPTH));
`ifdef IFQ_MISALIGN_CHECK_EN
    pc_misaligned = (io_pc[1:0] != 2'b00);
`else
    pc_misaligned = 1'b0;
`endif
    bus.io_imem_req_valid = space & ~pc_misaligned;
    bus.io_imem_req_addr  = io_pc;
    req_fire              = bus.io_imem_req_valid & bus.io_imem_req_ready;
    alloc_en              = req_fire | (space & pc_misaligned);
    // Released on a flush so the redirect target is taken immediately.
    io_stall_en           = reset | ~(alloc_en | io_flush);
    fill_en               = bus.io_imem_resp_valid & (drop_cnt_q == '0) & ~io_flush & ~reset & has_unfilled;
    bus.io_dec_valid      = head_entry.filled & ~io_flush & ~reset;
    pop_en                = bus.io_dec_valid & bus.io_dec_ready;
    bus.io_dec_pc         = head_entry.pc;
    bus.io_dec_inst       = head_entry.inst;
    bus.io_dec_misalign   = head_entry.misalign;
  end

  // Stale responses still owed by imem after a flush; they return before any new ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (io_flush) begin
      drop_cnt_d = drop_cnt_q + outstanding - CW'(bus.io_imem_resp_valid);
    end else if (bus.io_imem_resp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifq_ring #(.DEPTH(DEPTH)) u_ring (
    .clock          (clock),
    .reset          (reset),
    .clear          (io_flush),
    .alloc_en       (alloc_en),
    .alloc_pc       (io_pc),
    .alloc_misalign (pc_misaligned),
    .fill_en        (fill_en),
    .fill_inst      (bus.io_imem_resp_data),
    .pop_en         (pop_en),
    .head_entry     (head_entry),
    .cnt            (cnt),
    .outstanding    (outstanding),
    .has_unfilled   (has_unfilled)
  );

  resp_has_target: assert property (@(posedge clock) disable iff (reset)
    (bus.io_imem_resp_valid && (drop_cnt_q == '0)) |-> has_unfilled);

  drop_cnt_bounded: assert property (@(posedge clock) disable iff (reset)
    drop_cnt_q <= CW'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized fetch / imem / decode traffic for instr_fetch_queue, checked by a scoreboard
// against a queue-level reference model (issued PCs in order, responses tagged by flush epoch).
module tb_instr_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef IFQ_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          mis;
    bit          filled;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          epoch;
    int          issue;
  } req_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] io_pc;
  logic        io_flush;
  logic        io_stall_en;

  instr_fetch_queue_if #(.XLEN(XLEN)) bus ();

  instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_pc       (io_pc),
    .io_flush    (io_flush),
    .io_stall_en (io_stall_en),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  exp_t        exp_q[$];
  req_t        pend_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  bit          run      = 1'b0;
  logic [31:0] pc_reg;
  bit          pred_req_valid, pred_stall, pred_dec_valid, pred_alloc, cur_mis, resp_now;
  req_t        resp_req;
  int          p_ready, p_resp, p_dec, p_flush, p_mis, lat;
  bit          seq_pc, force_flush, flush_at_en;
  logic [31:0] flush_at_pc, flush_target;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic logic [31:0] randomPc();
    logic [31:0] p;
    p = $urandom;
    p[1:0] = roll(p_mis) ? 2'($urandom_range(3)) : 2'b00;
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, required);
    end
  endtask

  // Drives one cycle of fetch, imem and decode inputs and records what the model predicts.
  task automatic applyStimulus();
    io_pc    = pc_reg;
    io_flush = 1'b0;
    if (!reset) io_flush = force_flush || (flush_at_en && pc_reg == flush_at_pc) || roll(p_flush);
    cur_mis = MIS_EN && (pc_reg[1:0] != 2'b00);
    resp_now = 1'b0;
    bus.io_imem_resp_valid = 1'b0;
    bus.io_imem_resp_data  = $urandom;
    if (!reset && pend_q.size() > 0 && cyc >= pend_q[0].issue + lat && roll(p_resp)) begin
      resp_req = pend_q.pop_front();
      resp_now = 1'b1;
      bus.io_imem_resp_valid = 1'b1;
      bus.io_imem_resp_data  = mem_word(resp_req.pc);
    end
    bus.io_imem_req_ready = (pend_q.size() < DEPTH) && roll(p_ready);
    bus.io_dec_ready      = roll(p_dec);
    pred_req_valid = !reset && !io_flush && exp_q.size() < DEPTH && !cur_mis;
    pred_alloc     = !reset && !io_flush && exp_q.size() < DEPTH && (cur_mis || bus.io_imem_req_ready);
    pred_stall     = reset || !(pred_alloc || io_flush);
    pred_dec_valid = !reset && !io_flush && exp_q.size() > 0 && exp_q[0].filled;
  endtask

  // Applies the events of the cycle that just ended to the reference model.
  task automatic updateModel();
    bit hit;
    hit = 1'b0;
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      pc_reg = '0;
      epoch  = 0;
      return;
    end
    if (resp_now && resp_req.epoch == epoch) begin
      foreach (exp_q[i]) begin
        if (!hit && !exp_q[i].filled) begin
          exp_q[i].filled = 1'b1;
          hit = 1'b1;
        end
      end
    end
    if (io_flush) begin
      exp_q.delete();
      epoch++;
      pc_reg       = flush_target;
      force_flush  = 1'b0;
      flush_at_en  = 1'b0;
      flush_target = randomPc();
    end else begin
      if (pred_alloc) begin
        exp_q.push_back('{pc: io_pc, inst: mem_word(io_pc), mis: cur_mis, filled: cur_mis});
        if (!cur_mis) pend_q.push_back('{pc: io_pc, epoch: epoch, issue: cyc});
      end
      if (!pred_stall) pc_reg = seq_pc ? pc_reg + 32'd4 : randomPc();
    end
  endtask

  task automatic doCycle(input bit rst);
    @(posedge clock);
    #1;
    updateModel();
    cyc++;
    reset = rst;
    applyStimulus();
  endtask

  task automatic setKnobs(input int rdy, input int rsp, input int dec, input int fl, input int mis, input int l);
    p_ready = rdy; p_resp = rsp; p_dec = dec; p_flush = fl; p_mis = mis; lat = l;
  endtask

  // Scoreboard monitor: compares control outputs every cycle and pops on each decode handshake.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (run) begin
      checkOutput("req_valid", 32'(bus.io_imem_req_valid), 32'(pred_req_valid));
      checkOutput("stall_en", 32'(io_stall_en), 32'(pred_stall));
      checkOutput("dec_valid", 32'(bus.io_dec_valid), 32'(pred_dec_valid));
      if (pred_req_valid) checkOutput("req_addr", bus.io_imem_req_addr, io_pc);
      if (bus.io_dec_valid === 1'b1 && bus.io_dec_ready === 1'b1) begin
        if (exp_q.size() > 0 && exp_q[0].filled) begin
          e = exp_q.pop_front();
          checkOutput("dec_pc", bus.io_dec_pc, e.pc);
          if (!e.mis) checkOutput("dec_inst", bus.io_dec_inst, e.inst);
          checkOutput("dec_misalign", 32'(bus.io_dec_misalign), 32'(e.mis));
        end else begin
          checkOutput("dec_unexpected_pop", 32'(bus.io_dec_valid), 32'(0));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    pc_reg = '0;
    seq_pc = 1'b1;
    force_flush = 1'b0;
    flush_at_en = 1'b0;
    flush_at_pc = '0;
    flush_target = 32'h40;
    setKnobs(100, 100, 100, 0, 0, 1);
    applyStimulus();
    run = 1'b1;

    $display("[TB] reset and streaming");
    doCycle(1'b1);
    doCycle(1'b0);
    repeat (20) doCycle(1'b0);

    $display("[TB] full queue and single pop");
    p_dec = 0;
    repeat (10) doCycle(1'b0);
    p_dec = 100;
    doCycle(1'b0);
    p_dec = 0;
    repeat (4) doCycle(1'b0);
    p_dec = 100;
    repeat (10) doCycle(1'b0);

    $display("[TB] flush with requests in flight");
    doCycle(1'b1);
    lat = 3;
    flush_at_pc = 32'h8;
    flush_at_en = 1'b1;
    flush_target = 32'h40;
    doCycle(1'b1);
    doCycle(1'b0);
    repeat (15) doCycle(1'b0);
    flush_at_en = 1'b0;

    $display("[TB] simultaneous alloc/response/pop across wrap");
    lat = 1;
    repeat (16) doCycle(1'b0);

    $display("[TB] misaligned pc");
    force_flush = 1'b1;
    flush_target = 32'h6;
    repeat (10) doCycle(1'b0);
    force_flush = 1'b1;
    flush_target = 32'h100;
    repeat (10) doCycle(1'b0);

    $display("[TB] random traffic");
    for (int blk = 0; blk < 15; blk++) begin
      setKnobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)), int'($urandom_range(100, 10)),
               int'($urandom_range(6)), int'($urandom_range(30)), int'($urandom_range(4, 1)));
      seq_pc = 1'($urandom_range(1));
      if (blk % 5 == 4) doCycle(1'b1);
      repeat (200) doCycle(1'b0);
    end

    setKnobs(100, 100, 100, 0, 0, 1);
    repeat (30) doCycle(1'b0);
    run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
